// File: rtl/riscv_pkg.sv
// Shared widths, instruction field positions and reset defaults for the fetch front end.
// Parameters only: no logic, no latency, no backpressure.
// Field slices follow the base RV32 encoding.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_W     = 32;
    localparam int FETCH_DEPTH = 2;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 6;
    localparam int F3_LSB   = 12;
    localparam int F3_MSB   = 14;
    localparam int F7_5_BIT = 30;

    localparam logic [XLEN-1:0] RESET_PC = '0;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of memory request/response, redirect and decode-side handshakes.
// Pure wiring: no latency; valid/ready on requests and decode, valid-only on responses.
// The master modport is the fetch unit, the slave modport is its environment.
interface fetch_unit_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
);

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    instr_pc;
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct75;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, op, funct3, funct75,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, op, funct3, funct75,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} entries with flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller's credit scheme keeps pushes within capacity.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int W     = INSTR_W + XLEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    // A pop frees its slot in the same cycle, so a full FIFO may still accept a push.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem requests, response buffering, redirect flush.
// Latency: request -> response -> head valid the cycle after the response (no bypass).
// Backpressure: requests throttled so buffered + outstanding never exceeds DEPTH.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              DEPTH    = FETCH_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = INSTR_W + XLEN;

    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    resp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      outstanding_next;
    logic [CW-1:0]      drop_cnt;
    logic [CW-1:0]      fifo_count;
    logic [XLEN-1:0]    redirect_tgt;
    logic [EW-1:0]      head;
    logic [INSTR_W-1:0] head_instr;
    logic               req_fire;
    logic               resp_ok;
    logic               resp_drop;
    logic               push;
    logic               pop;

    assign bus.imem_req_valid = !rst && !bus.redirect_valid &&
                                ((32'(fifo_count) + 32'(outstanding)) < 32'(DEPTH));
    assign bus.imem_addr      = pc;

    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok   = bus.imem_resp_valid && (outstanding != '0);
    assign resp_drop = resp_ok && (drop_cnt != '0);
    assign push      = resp_ok && !resp_drop;
    assign pop       = bus.instr_valid && bus.instr_ready;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_ok);
    assign redirect_tgt     = bus.redirect_pc & ~XLEN'(3);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata ({bus.imem_rdata, resp_pc}),
        .rdata (head),
        .count (fifo_count)
    );

    // Head fields are masked while empty so stale storage never leaks to decode.
    assign bus.instr_valid = (fifo_count != '0);
    assign head_instr      = bus.instr_valid ? head[EW-1:XLEN] : '0;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = bus.instr_valid ? head[XLEN-1:0] : '0;
    assign bus.op          = head_instr[OP_MSB:OP_LSB];
    assign bus.funct3      = head_instr[F3_MSB:F3_LSB];
    assign bus.funct75     = head_instr[F7_5_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (bus.redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc       <= redirect_tgt;
                resp_pc  <= redirect_tgt;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire)  pc       <= pc + XLEN'(4);
                if (push)      resp_pc  <= resp_pc + XLEN'(4);
                if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle in-order instruction memory model.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_en;
    int   vectors     = 0;
    int   miscompares = 0;
    int   acc_cnt;
    logic [31:0] pend [$];

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h40005033 ^ (a << 8);
    endfunction

    // Memory: accepted addresses queue up; the oldest answers one cycle later while mem_en is high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            acc_cnt              <= 0;
            bus.imem_resp_valid  <= 1'b0;
            bus.imem_rdata       <= '0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back(bus.imem_addr);
                acc_cnt <= acc_cnt + 1;
            end
            if (mem_en && pend.size() > 0) begin
                bus.imem_resp_valid <= 1'b1;
                bus.imem_rdata      <= word(pend.pop_front());
            end else begin
                bus.imem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst                = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b1;
        mem_en             = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_valid",   bus.imem_req_valid, 0);
        chk("rst_addr",        bus.imem_addr,      0);
        chk("rst_instr_valid", bus.instr_valid,    0);
        chk("rst_instr",       bus.instr,          0);
        chk("rst_instr_pc",    bus.instr_pc,       0);
        chk("rst_op",          bus.op,             0);

        // 1: streaming fetch from RESET_PC
        rst = 1'b0;
        #1;
        chk("t1_req_valid0", bus.imem_req_valid, 1);
        chk("t1_addr0",      bus.imem_addr,      32'h0);
        @(negedge clk);
        chk("t1_n1_ivalid",  bus.instr_valid,    0);
        chk("t1_addr4",      bus.imem_addr,      32'h4);
        @(negedge clk);
        chk("t1_n2_ivalid",  bus.instr_valid,    1);
        chk("t1_pc0",        bus.instr_pc,       32'h0);
        chk("t1_instr0",     bus.instr,          32'h40005033);
        chk("t1_op",         bus.op,             7'h33);
        chk("t1_funct3",     bus.funct3,         3'd5);
        chk("t1_funct75",    bus.funct75,        1'b1);
        chk("t1_credit_stall", bus.imem_req_valid, 0);
        @(negedge clk);
        chk("t1_pc4",        bus.instr_pc,       32'h4);
        chk("t1_instr4",     bus.instr,          32'h40005433);
        chk("t1_addr8",      bus.imem_addr,      32'h8);
        @(negedge clk);
        chk("t1_n4_ivalid",  bus.instr_valid,    0);
        chk("t1_addr12",     bus.imem_addr,      32'hC);
        @(negedge clk);
        chk("t1_pc8",        bus.instr_pc,       32'h8);

        // 2: decode stalled, credits cap requests at DEPTH
        apply_reset();
        bus.instr_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_full_req_valid", bus.imem_req_valid, 0);
        chk("t2_full_ivalid",    bus.instr_valid,    1);
        chk("t2_full_head_pc",   bus.instr_pc,       32'h0);
        repeat (3) @(negedge clk);
        chk("t2_still_blocked",  bus.imem_req_valid, 0);
        chk("t2_accepted",       acc_cnt,            2);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("t2_pc4",            bus.instr_pc,       32'h4);
        chk("t2_resume_valid",   bus.imem_req_valid, 1);
        chk("t2_resume_addr",    bus.imem_addr,      32'h8);
        @(negedge clk);
        chk("t2_drained",        bus.instr_valid,    0);
        @(negedge clk);
        chk("t2_pc8",            bus.instr_pc,       32'h8);

        // 3: redirect with two responses in flight
        apply_reset();
        mem_en = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t3_two_out_blocked", bus.imem_req_valid, 0);
        chk("t3_accepted",        acc_cnt,            2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        chk("t3_redir_no_req",    bus.imem_req_valid, 0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        mem_en = 1'b1;
        #1;
        chk("t3_new_addr",        bus.imem_addr,      32'h100);
        chk("t3_wait_stale",      bus.imem_req_valid, 0);
        @(negedge clk);
        chk("t3_n4_ivalid",       bus.instr_valid,    0);
        @(negedge clk);
        chk("t3_n5_ivalid",       bus.instr_valid,    0);
        chk("t3_n5_req",          bus.imem_req_valid, 1);
        chk("t3_n5_addr",         bus.imem_addr,      32'h100);
        @(negedge clk);
        chk("t3_stale_dropped",   bus.instr_valid,    0);
        @(negedge clk);
        chk("t3_first_valid",     bus.instr_valid,    1);
        chk("t3_first_pc",        bus.instr_pc,       32'h100);
        chk("t3_first_instr",     bus.instr,          32'h40015033);

        // 4: redirect coinciding with a response and a pop, then a back-to-back redirect
        apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_head_before",     bus.instr_valid,    1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        #1;
        chk("t4_redir_no_req",    bus.imem_req_valid, 0);
        @(negedge clk);
        chk("t4_flushed",         bus.instr_valid,    0);
        bus.redirect_pc = 32'h80;
        #1;
        chk("t4_b2b_no_req",      bus.imem_req_valid, 0);
        chk("t4_b2b_addr_old",    bus.imem_addr,      32'h40);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_req_valid",       bus.imem_req_valid, 1);
        chk("t4_addr80",          bus.imem_addr,      32'h80);
        @(negedge clk);
        chk("t4_n5_ivalid",       bus.instr_valid,    0);
        @(negedge clk);
        chk("t4_pc80",            bus.instr_pc,       32'h80);
        chk("t4_instr80",         bus.instr,          32'h4000D033);

        // 5: memory not ready for three cycles
        apply_reset();
        bus.imem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_req_valid",       bus.imem_req_valid, 1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t5_addr_held",   bus.imem_addr,      32'h0);
            chk("t5_valid_held",  bus.imem_req_valid, 1);
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        chk("t5_addr_adv",        bus.imem_addr,      32'h4);
        @(negedge clk);
        chk("t5_ivalid",          bus.instr_valid,    1);
        chk("t5_pc0",             bus.instr_pc,       32'h0);

        // 6: asynchronous reset with a full buffer
        apply_reset();
        bus.instr_ready = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_full",            bus.instr_valid,    1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_ivalid",    bus.instr_valid,    0);
        chk("t6_async_req",       bus.imem_req_valid, 0);
        chk("t6_async_addr",      bus.imem_addr,      32'h0);
        chk("t6_async_pc",        bus.instr_pc,       32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        chk("t6_restart_req",     bus.imem_req_valid, 1);
        chk("t6_restart_addr",    bus.imem_addr,      32'h0);
        @(negedge clk);
        chk("t6_addr4",           bus.imem_addr,      32'h4);
        @(negedge clk);
        chk("t6_pc0",             bus.instr_pc,       32'h0);

        // 7: unaligned redirect target and PC wrap-around
        apply_reset();
        rst = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        #1;
        chk("t7_redir_no_req",    bus.imem_req_valid, 0);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t7_addr_top",        bus.imem_addr,      32'hFFFF_FFFC);
        chk("t7_req",             bus.imem_req_valid, 1);
        @(negedge clk);
        chk("t7_addr_wrap",       bus.imem_addr,      32'h0);
        @(negedge clk);
        chk("t7_pc_top",          bus.instr_pc,       32'hFFFF_FFFC);
        chk("t7_op",              bus.op,             7'h33);
        chk("t7_funct3",          bus.funct3,         3'd2);
        chk("t7_funct75",         bus.funct75,        1'b0);
        @(negedge clk);
        chk("t7_resp_pc_wrap",    bus.instr_pc,       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
